// File: rtl/uart_rx_framed.sv
// UART receiver: configurable data/parity/stop framing, 3-sample majority vote,
// parity/frame/break/overrun detection and a receive FIFO on a valid/ready source.
module uart_rx_framed #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        rxd_i,
  output logic [DATA_BITS-1:0]        tdata_o,
  output logic                        tvalid_o,
  input  logic                        tready_i,
  output logic                        parity_error_o,
  output logic                        frame_error_o,
  output logic                        break_detect_o,
  output logic                        overrun_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 4;
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BREAK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop0_q, stop0_d;
  logic                 ferr_q, ferr_d;
  logic                 pe_q, pe_d, fe_q, fe_d, bk_q, bk_d, ov_q;

  logic [1:0]           sync_q, hist_q;
  logic                 prev_q;
  logic                 sample_c, bit_done_c, push_c;
  logic                 first_stop_c, frame_bad_c, data_par_c, perr_c, brk_c;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d, count_q, count_d;
  logic [DATA_BITS-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 full_c, pop_c, wr_en_c, ov_c;

  // Two-flop synchroniser, vote history and edge-detect register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      hist_q <= {hist_q[0], sync_q[1]};
      prev_q <= sample_c;
    end
  end

  assign sample_c = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop0_q <= 1'b0;
      ferr_q  <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bk_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop0_q <= stop0_d;
      ferr_q  <= ferr_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bk_q    <= bk_d;
      ov_q    <= ov_c;
    end
  end

  // Character checks, valid only on the final stop sample.
  always_comb begin
    bit_done_c   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    first_stop_c = (idx_q == '0) ? sample_c : stop0_q;
    frame_bad_c  = ferr_q | ~sample_c;
    data_par_c   = (^shift_q) ^ par_q;
    perr_c       = (PARITY == 1) ? ~data_par_c : ((PARITY == 2) ? data_par_c : 1'b0);
    brk_c        = (shift_q == '0) && ((PARITY == 0) || !par_q) && !first_stop_c;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop0_d = stop0_q;
    ferr_d  = ferr_q;
    push_c  = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    bk_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (prev_q && !sample_c) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_W'(HALF)) begin
          cnt_d   = '0;
          state_d = sample_c ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done_c) begin
          cnt_d = '0;
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IDX_W'(i)) shift_d[i] = sample_c;
          end
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            ferr_d  = 1'b0;
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAR: begin
        if (bit_done_c) begin
          cnt_d   = '0;
          par_d   = sample_c;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done_c) begin
          cnt_d = '0;
          if (idx_q == '0) stop0_d = sample_c;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (brk_c) begin
              bk_d    = 1'b1;
              state_d = ST_BREAK_WAIT;
            end else begin
              state_d = ST_IDLE;
              if (frame_bad_c) begin
                fe_d = 1'b1;
                pe_d = perr_c;
              end else if (perr_c) begin
                pe_d = 1'b1;
              end else begin
                push_c = 1'b1;
              end
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            ferr_d = frame_bad_c;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK_WAIT: begin
        if (sample_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO control; head, valid and count are registered from next-state pointers.
  always_comb begin
    full_c   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_c    = tvalid_q & tready_i;
    wr_en_c  = push_c & (~full_c | pop_c);
    ov_c     = push_c & full_c & ~pop_c;
    wr_d     = wr_q + PW'(wr_en_c);
    rd_d     = rd_q + PW'(pop_c);
    count_d  = wr_d - rd_d;
    tvalid_d = (wr_d != rd_d);
    tdata_d  = tdata_q;
    if (wr_en_c && (rd_d == wr_q)) begin
      tdata_d = shift_q;
    end else if (rd_d != wr_q) begin
      tdata_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_c) mem_q[wr_q[AW-1:0]] <= shift_q;
  end

  assign tdata_o        = tdata_q;
  assign tvalid_o       = tvalid_q;
  assign fifo_count_o   = count_q;
  assign parity_error_o = pe_q;
  assign frame_error_o  = fe_q;
  assign break_detect_o = bk_q;
  assign overrun_o      = ov_q;

endmodule
